// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction memory port, decode handshake,
// execute-stage redirect and occupancy.
interface fetch_queue_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc4;
    logic              redirect;
    logic [1:0]        br_sel;
    logic [ADDR_W-1:0] br_pc;
    logic [25:0]       br_imm;
    logic [ADDR_W-1:0] br_reg;
    logic [CW-1:0]     occupancy;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output out_pc4,
        input  redirect,
        input  br_sel,
        input  br_pc,
        input  br_imm,
        input  br_reg,
        output occupancy
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  out_pc4,
        output redirect,
        output br_sel,
        output br_pc,
        output br_imm,
        output br_reg,
        input  occupancy
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC register, prefetch queue of
// {pc, inst} pairs, branch target generation and redirect flush.
module fetch_queue_unit #(
    parameter int              ADDR_W   = 64,
    parameter int              INST_W   = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_pc_q   [QDEPTH];
    logic [INST_W-1:0] r_inst_q [QDEPTH];

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [ADDR_W-1:0] w_off19;
    logic [ADDR_W-1:0] w_off26;
    logic [ADDR_W-1:0] w_reg_tgt;
    logic [ADDR_W-1:0] w_target;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(QDEPTH));
    assign w_pop   = ~w_empty & bus.out_ready & ~bus.redirect;
    assign w_push  = ~bus.redirect & (~w_full | w_pop);

    // Offsets are word counts: sign-extend, then scale by 4.
    assign w_off19 = {{(ADDR_W-21){bus.br_imm[18]}},
                      bus.br_imm[18:0], 2'b00};
    assign w_off26 = {{(ADDR_W-28){bus.br_imm[25]}},
                      bus.br_imm[25:0], 2'b00};
    assign w_reg_tgt = bus.br_reg & ~ADDR_W'(3);

    always_comb begin
        w_target = w_reg_tgt;
        unique case (1'b1)
            (bus.br_sel == 2'b00): w_target = bus.br_pc + w_off19;
            (bus.br_sel == 2'b01): w_target = bus.br_pc + w_off26;
            default:               w_target = w_reg_tgt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= w_target;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                r_wr       <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload needs no reset; the count alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr]   <= r_fetch_pc;
            r_inst_q[r_wr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr = r_fetch_pc;
    assign bus.out_valid = ~w_empty;
    assign bus.out_inst  = r_inst_q[r_rd];
    assign bus.out_pc    = r_pc_q[r_rd];
    assign bus.out_pc4   = r_pc_q[r_rd] + ADDR_W'(4);
    assign bus.occupancy = r_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a queue-based reference
// model compared every cycle plus literal spot checks.
module tb_fetch_queue_unit;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(AW), .INST_W(IW), .QDEPTH(QD)) bus ();

    fetch_queue_unit #(
        .ADDR_W(AW), .INST_W(IW), .QDEPTH(QD), .RESET_PC('0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hE3A0_0000;
    endfunction

    assign bus.imem_rdata = mem(bus.imem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] m_q[$];
    logic [AW-1:0] m_fpc;
    bit            m_ok = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] tgt();
        longint off;
        logic signed [18:0] s19;
        logic signed [25:0] s26;
        s19 = bus.br_imm[18:0];
        s26 = bus.br_imm;
        case (bus.br_sel)
            2'b00: begin
                off = longint'(s19) * 4;
                return bus.br_pc + AW'(off);
            end
            2'b01: begin
                off = longint'(s26) * 4;
                return bus.br_pc + AW'(off);
            end
            default: return (bus.br_reg / 4) * 4;
        endcase
    endfunction

    task automatic compare();
        if (m_ok) begin
            chk("occupancy", 64'(bus.occupancy), 64'(m_q.size()));
            chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
            chk("imem_addr", bus.imem_addr, m_fpc);
            if (m_q.size() != 0) begin
                chk("out_pc",   bus.out_pc,   m_q[0]);
                chk("out_pc4",  bus.out_pc4,  m_q[0] + 4);
                chk("out_inst", 64'(bus.out_inst), 64'(mem(m_q[0])));
            end
        end
    endtask

    // Model advances with the inputs that will be sampled on the coming edge.
    task automatic model_tick();
        bit pop;
        bit push;
        if (reset) begin
            m_q.delete();
            m_fpc = '0;
            m_ok  = 1;
        end else if (m_ok) begin
            if (bus.redirect) begin
                m_q.delete();
                m_fpc = tgt();
            end else begin
                pop  = (m_q.size() != 0) && bus.out_ready;
                push = (m_q.size() < QD) || pop;
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(m_fpc);
                    m_fpc = m_fpc + 4;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] sel, input logic [AW-1:0] pc,
                         input logic [25:0] imm, input logic [AW-1:0] rg);
        bus.redirect = 1'b1;
        bus.br_sel   = sel;
        bus.br_pc    = pc;
        bus.br_imm   = imm;
        bus.br_reg   = rg;
        step();
        bus.redirect = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect  = 1'b0;
        bus.br_sel    = 2'b00;
        bus.br_pc     = '0;
        bus.br_imm    = '0;
        bus.br_reg    = '0;
        step();
        step();
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_addr", bus.imem_addr, 64'd0);
        reset = 1'b0;
        step();
        chk("first_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", bus.out_pc, 64'(4 * i));
            chk("seq_pc4", bus.out_pc4, 64'(4 * i + 4));
            step();
        end

        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("full_occ", 64'(bus.occupancy), 64'd4);
        chk("full_addr", bus.imem_addr, 64'd16);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_pc", bus.out_pc, 64'(4 * i));
            if (i == 1) chk("full_pop_occ", 64'(bus.occupancy), 64'd4);
            step();
        end

        redir(2'b00, 64'h40, 26'h007FFFF, '0);
        chk("redir_valid", 64'(bus.out_valid), 64'd0);
        chk("redir_occ", 64'(bus.occupancy), 64'd0);
        chk("redir_addr", bus.imem_addr, 64'h3C);
        step();
        chk("cond_tgt", bus.out_pc, 64'h3C);

        redir(2'b01, 64'h100, 26'h0000010, '0);
        step();
        chk("unc_tgt", bus.out_pc, 64'h140);
        redir(2'b01, 64'h1000, 26'h3FFFFF0, '0);
        step();
        chk("unc_neg_tgt", bus.out_pc, 64'hFC0);
        redir(2'b10, '0, '0, 64'h203);
        step();
        chk("reg_tgt", bus.out_pc, 64'h200);
        redir(2'b11, '0, '0, 64'h30F);
        step();
        chk("rsv_tgt", bus.out_pc, 64'h30C);

        bus.redirect = 1'b1;
        bus.br_sel   = 2'b10;
        bus.br_reg   = 64'h500;
        step();
        bus.br_reg   = 64'h600;
        step();
        bus.redirect = 1'b0;
        step();
        chk("b2b_tgt", bus.out_pc, 64'h600);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_flush_occ", 64'(bus.occupancy), 64'd4);
        bus.out_ready = 1'b1;
        redir(2'b10, '0, '0, 64'h800);
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        step();
        chk("flush_pc0", bus.out_pc, 64'h800);
        step();
        chk("flush_pc1", bus.out_pc, 64'h804);

        redir(2'b10, '0, '0, '1);
        step();
        chk("wrap_head", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", bus.imem_addr, 64'd0);
        step();
        chk("wrap_pc", bus.out_pc, 64'd0);

        bus.out_ready = 1'b0;
        step();
        step();
        chk("mid_occ", 64'(bus.occupancy), 64'd3);
        reset = 1'b1;
        step();
        chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_addr", bus.imem_addr, 64'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the pipelined ARM core. It replaces the single-cycle PC/branch-adder path with a PC register, a prefetch queue of {pc, instruction} pairs and a valid/ready handshake to decode. Branch targets for conditional (19-bit), unconditional (26-bit) and register (BR) forms are computed internally. Redirects from the execute stage flush all queued instructions.

Parameters:
ADDR_W, 64, PC/address width in bits.
INST_W, 32, instruction width in bits.
QDEPTH, 4, prefetch queue entries; power of two, 2..16.
RESET_PC, 0, PC value loaded on reset (ADDR_W bits, word aligned).

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-high.
imem_addr  output  ADDR_W  fetch address to instruction memory; equals fetch_pc.
imem_rdata  input  INST_W  instruction at imem_addr, combinational (same cycle).
out_valid  output  1  queue head holds a valid instruction.
out_ready  input  1  decode accepts the head this cycle.
out_inst  output  INST_W  head instruction.
out_pc  output  ADDR_W  PC of head instruction.
out_pc4  output  ADDR_W  out_pc + 4; link value for BL.
redirect  input  1  execute stage resolved a taken branch this cycle.
br_sel  input  2  00 cond (imm19), 01 uncond (imm26), 10 register, 11 reserved (treated as 10).
br_pc  input  ADDR_W  PC of the branch instruction.
br_imm  input  26  offset field; bits [18:0] used when br_sel=00.
br_reg  input  ADDR_W  register value for BR.
occupancy  output  $clog2(QDEPTH)+1  queued entry count.

Behaviour:
- Reset (synchronous, has priority over everything): fetch_pc<=RESET_PC, rd/wr pointers<=0, count<=0. Result: out_valid=0, occupancy=0. out_inst/out_pc/out_pc4 are don't-care while out_valid=0. Reset mid-stream discards all entries.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & (count<QDEPTH | pop). Simultaneous pop and push is allowed when full.
- On push: entry[wr] <= {fetch_pc, imem_rdata}; wr<=wr+1 mod QDEPTH; fetch_pc<=fetch_pc+4 (mod 2^ADDR_W, wraps silently).
- On pop: rd<=rd+1 mod QDEPTH.
- count <= count + push - pop.
- Full with no pop: no push; fetch_pc holds; imem_addr stays stable.
- Latency: an instruction is visible at the outputs the cycle after its push. First out_valid=1 is one cycle after reset deasserts.
- Outputs come from registered queue storage; no combinational path from imem_rdata to out_*.
- Redirect (priority over push/pop): count<=0, pointers<=0, fetch_pc<=target, no push, no pop that cycle. out_valid=0 the next cycle. The target's instruction is pushed in the cycle after the redirect and is visible two cycles after the redirect.
- Target computation:
  - br_sel=00: br_pc + (sext64(br_imm[18:0])<<2).
  - br_sel=01: br_pc + (sext64(br_imm[25:0])<<2).
  - br_sel=1x: {br_reg[ADDR_W-1:2],2'b00} (misaligned low bits forced to zero).
  - Sign extension is to ADDR_W; adds wrap modulo 2^ADDR_W.
- out_pc4 = out_pc + 4, combinational from the head entry.
- Back-to-back redirects: each cycle's target wins; only the last one takes effect.
- occupancy == count, registered.

Test Plan:
1. Reset, RESET_PC=0, out_ready=1, imem_rdata=PC-derived pattern -> out_valid rises 1 cycle after reset drops; out_pc = 0,4,8,12 on consecutive cycles; out_pc4 = out_pc+4.
2. out_ready=0 for 10 cycles, QDEPTH=4 -> occupancy reaches 4 after 4 cycles and holds; imem_addr frozen at 16. Then out_ready=1 -> pcs 0,4,8,12,16,20 in order, no gap or duplicate, full-and-pop pushes 16 in the same cycle.
3. Redirect with br_sel=00, br_pc=0x40, br_imm[18:0]=0x7FFFF (-1) -> next cycle out_valid=0, occupancy=0; following cycle out_pc=0x3C.
4. Redirect br_sel=01, br_pc=0x100, br_imm=0x0000010 -> target 0x140. Redirect br_sel=10, br_reg=0x203 -> target 0x200.
5. Redirect asserted with out_ready=1 and queue full -> no entry consumed that cycle; all stale entries discarded; only target-stream pcs appear afterwards.
6. fetch_pc=2^ADDR_W-4 (via BR redirect to all-ones aligned) -> next pushed pc wraps to 0. Reset asserted mid-stream with occupancy=3 -> next cycle occupancy=0, out_valid=0, imem_addr=RESET_PC.
